// File: rtl/anchor_point_detector_if.sv
// Bundle of VGA scan, object position and anchor summary signals between the
// position registers, the anchor point detector and the game-control logic.
interface anchor_point_detector_if #(
    parameter int NUM_OBJ = 4,
    parameter int COORD_W = 11
) ();
    localparam int CNT_W = $clog2(NUM_OBJ + 1);

    logic                       startOfFrame;
    logic [COORD_W-1:0]         pixelX;
    logic [COORD_W-1:0]         pixelY;
    logic [NUM_OBJ*COORD_W-1:0] topLeftX;
    logic [NUM_OBJ*COORD_W-1:0] topLeftY;
    logic [NUM_OBJ-1:0]         objValid;

    logic [NUM_OBJ-1:0]         is_local;
    logic [NUM_OBJ-1:0]         frame_hits;
    logic [NUM_OBJ-1:0]         frame_missed;
    logic [CNT_W-1:0]           hit_count;
    logic                       summary_valid;

    modport master (
        output startOfFrame, pixelX, pixelY, topLeftX, topLeftY, objValid,
        input  is_local, frame_hits, frame_missed, hit_count, summary_valid
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY, objValid,
        output is_local, frame_hits, frame_missed, hit_count, summary_valid
    );
endinterface

// File: rtl/anchor_point_detector.sv
// Flags the scan cycle at which each object's anchor point is reached and
// publishes a per-frame hit/miss summary at every startOfFrame.
module anchor_point_detector #(
    parameter int NUM_OBJ  = 4,
    parameter int COORD_W  = 11,
    parameter int OFFSET_X = 16,
    parameter int OFFSET_Y = 16
) (
    input  logic                    clk,
    input  logic                    resetN,
    anchor_point_detector_if.slave  bus
);
    // state | meaning
    // IDLE  | after reset; prior frame incomplete, no accumulation, summary held 0
    // ARMED | accumulating hits; each startOfFrame closes and publishes a frame
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam int                 CNT_W = $clog2(NUM_OBJ + 1);
    localparam logic [COORD_W-1:0] OFF_X = COORD_W'(OFFSET_X);
    localparam logic [COORD_W-1:0] OFF_Y = COORD_W'(OFFSET_Y);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_close;
    logic [NUM_OBJ-1:0] w_hit;
    logic [COORD_W-1:0] w_anchor_x [NUM_OBJ];
    logic [COORD_W-1:0] w_anchor_y [NUM_OBJ];

    logic [NUM_OBJ-1:0] r_acc;
    logic [NUM_OBJ-1:0] r_is_local;
    logic [NUM_OBJ-1:0] r_frame_hits;
    logic [NUM_OBJ-1:0] r_frame_missed;
    logic [CNT_W-1:0]   r_hit_count;
    logic               r_summary_valid;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_OBJ-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Anchor sums wrap modulo 2^COORD_W, so negative positions work unchanged.
    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_ch
        assign w_anchor_x[g] = bus.topLeftX[g*COORD_W +: COORD_W] + OFF_X;
        assign w_anchor_y[g] = bus.topLeftY[g*COORD_W +: COORD_W] + OFF_Y;
        assign w_hit[g]      = bus.objValid[g]
                               && (bus.pixelX == w_anchor_x[g])
                               && (bus.pixelY == w_anchor_y[g]);
    end

    assign w_close = (r_state == ARMED) && bus.startOfFrame;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.startOfFrame) w_next_state = ARMED;
            ARMED:   w_next_state = ARMED;
            default: w_next_state = IDLE;
        endcase
    end

    // A hit coinciding with startOfFrame seeds the new frame's accumulator,
    // including on the IDLE->ARMED transition.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_acc           <= '0;
            r_is_local      <= '0;
            r_frame_hits    <= '0;
            r_frame_missed  <= '0;
            r_hit_count     <= '0;
            r_summary_valid <= 1'b0;
        end else begin
            r_is_local      <= w_hit;
            r_summary_valid <= w_close;
            if (r_state == IDLE) begin
                r_acc <= bus.startOfFrame ? w_hit : '0;
            end else if (bus.startOfFrame) begin
                r_acc          <= w_hit;
                r_frame_hits   <= r_acc;
                r_frame_missed <= bus.objValid & ~r_acc;
                r_hit_count    <= popcount(r_acc);
            end else begin
                r_acc <= r_acc | w_hit;
            end
        end
    end

    assign bus.is_local      = r_is_local;
    assign bus.frame_hits    = r_frame_hits;
    assign bus.frame_missed  = r_frame_missed;
    assign bus.hit_count     = r_hit_count;
    assign bus.summary_valid = r_summary_valid;
endmodule

// File: tb/tb_anchor_point_detector.sv
// Scoreboard bench for anchor_point_detector: a frame-level reference model
// queues expected responses, an independent monitor pops and compares them.
module tb_anchor_point_detector;
    localparam int N  = 4;
    localparam int W  = 11;
    localparam int OX = 16;
    localparam int OY = 16;
    localparam int CW = $clog2(N + 1);

    typedef struct packed {
        logic [N-1:0] loc;
        logic         sv;
        logic         clr;
    } cyc_t;

    typedef struct packed {
        logic [N-1:0]  fh;
        logic [N-1:0]  fm;
        logic [CW-1:0] hc;
    } sum_t;

    logic clk = 1'b1;
    logic resetN;

    anchor_point_detector_if #(.NUM_OBJ(N), .COORD_W(W)) bus ();

    anchor_point_detector #(
        .NUM_OBJ(N), .COORD_W(W), .OFFSET_X(OX), .OFFSET_Y(OY)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    cyc_t         exp_cyc[$];
    sum_t         exp_sum[$];
    int           checks = 0;
    int           errors = 0;

    logic [W-1:0] tlx [N];
    logic [W-1:0] tly [N];
    logic [N-1:0] ov;
    bit           m_armed;
    bit           m_frame_hit [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] anc_x(input int ch);
        return W'((int'(tlx[ch]) + OX) % (1 << W));
    endfunction

    function automatic logic [W-1:0] anc_y(input int ch);
        return W'((int'(tly[ch]) + OY) % (1 << W));
    endfunction

    // One scan cycle: apply inputs and advance the frame-level model.
    task automatic drive(input logic rst, input logic sof,
                         input logic [W-1:0] px, input logic [W-1:0] py);
        logic [N-1:0] hit;
        cyc_t         c;
        sum_t         s;
        int           cnt;
        @(negedge clk);
        resetN           = rst;
        bus.startOfFrame = sof;
        bus.pixelX       = px;
        bus.pixelY       = py;
        for (int i = 0; i < N; i++) begin
            bus.topLeftX[i*W +: W] = tlx[i];
            bus.topLeftY[i*W +: W] = tly[i];
        end
        bus.objValid = ov;

        hit = '0;
        for (int i = 0; i < N; i++) begin
            if (ov[i] && px == anc_x(i) && py == anc_y(i)) hit[i] = 1'b1;
        end

        c = '{loc: hit, sv: 1'b0, clr: 1'b0};
        if (!rst) begin
            m_armed = 0;
            for (int i = 0; i < N; i++) m_frame_hit[i] = 0;
            c = '{loc: '0, sv: 1'b0, clr: 1'b1};
        end else if (sof) begin
            if (m_armed) begin
                cnt = 0;
                for (int i = 0; i < N; i++) begin
                    s.fh[i] = m_frame_hit[i];
                    s.fm[i] = ov[i] && !m_frame_hit[i];
                    if (m_frame_hit[i]) cnt++;
                end
                s.hc = CW'(cnt);
                exp_sum.push_back(s);
                c.sv = 1'b1;
            end
            m_armed = 1;
            for (int i = 0; i < N; i++) m_frame_hit[i] = hit[i];
        end else if (m_armed) begin
            for (int i = 0; i < N; i++) if (hit[i]) m_frame_hit[i] = 1;
        end
        exp_cyc.push_back(c);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, W'(0), W'(0));
    endtask

    task automatic hit_ch(input logic sof, input int ch);
        drive(1'b1, sof, anc_x(ch), anc_y(ch));
    endtask

    initial begin : monitor
        cyc_t c;
        sum_t s;
        sum_t held;
        held = '0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_cyc.size() == 0) begin
                chk("cycle_queue_underflow", 32'd1, 32'd0);
            end else begin
                c = exp_cyc.pop_front();
                chk("is_local", 32'(bus.is_local), 32'(c.loc));
                chk("summary_valid", 32'(bus.summary_valid), 32'(c.sv));
                if (c.clr) held = '0;
                if (bus.summary_valid === 1'b1 || c.sv) begin
                    if (exp_sum.size() == 0) begin
                        chk("unexpected_summary", 32'd1, 32'd0);
                    end else begin
                        s    = exp_sum.pop_front();
                        held = s;
                    end
                end
                chk("frame_hits", 32'(bus.frame_hits), 32'(held.fh));
                chk("frame_missed", 32'(bus.frame_missed), 32'(held.fm));
                chk("hit_count", 32'(bus.hit_count), 32'(held.hc));
            end
        end
    end

    initial begin : stimulus
        int a;
        int b;
        resetN = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.pixelX = '0;
        bus.pixelY = '0;
        bus.topLeftX = '0;
        bus.topLeftY = '0;
        bus.objValid = '0;
        m_armed = 0;
        for (int i = 0; i < N; i++) m_frame_hit[i] = 0;

        // Reset held with arbitrary inputs
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                tlx[i] = W'($urandom);
                tly[i] = W'($urandom);
            end
            ov = N'($urandom);
            drive(1'b0, 1'($urandom), W'($urandom), W'($urandom));
        end

        tlx[0] = 11'd100; tly[0] = 11'd50;
        tlx[1] = 11'd300; tly[1] = 11'd200;
        tlx[2] = 11'd500; tly[2] = 11'd400;
        tlx[3] = 11'd700; tly[3] = 11'd600;
        ov = 4'b0001;
        drive(1'b1, 1'b0, 11'd116, 11'd66);
        idle(3);
        drive(1'b1, 1'b1, 11'd0, 11'd0);  // first frame start: no summary
        ov = 4'b1111;
        idle(2);
        hit_ch(1'b0, 0);
        idle(2);
        hit_ch(1'b0, 2);
        idle(2);
        drive(1'b1, 1'b1, 11'd0, 11'd0);  // expect 0101 / 1010 / 2
        idle(3);

        // Wrap-around of a negative position
        tlx[0] = 11'h7F8; tly[0] = 11'd0;
        drive(1'b1, 1'b0, 11'd8, 11'd16);
        drive(1'b1, 1'b0, 11'd24, 11'd16);
        idle(1);

        // Hit coinciding with frame start belongs to the new frame
        hit_ch(1'b1, 1);
        idle(3);
        drive(1'b1, 1'b1, 11'd0, 11'd0);
        drive(1'b1, 1'b1, 11'd0, 11'd0);  // back-to-back frame start
        idle(2);

        // Masked channel
        ov = 4'b0111;
        hit_ch(1'b0, 3);
        idle(2);
        drive(1'b1, 1'b1, 11'd0, 11'd0);
        idle(2);

        // Mid-frame reset
        ov = 4'b1111;
        hit_ch(1'b0, 0);
        hit_ch(1'b0, 1);
        idle(1);
        drive(1'b0, 1'b0, 11'd0, 11'd0);
        idle(2);
        drive(1'b1, 1'b1, 11'd0, 11'd0);  // no summary after reset
        hit_ch(1'b0, 2);
        idle(2);
        drive(1'b1, 1'b1, 11'd0, 11'd0);  // only channel 2
        idle(2);

        // Randomized scan with occasional repositioning, shared anchors and resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int i = 0; i < N; i++) begin
                    tlx[i] = W'($urandom);
                    tly[i] = W'($urandom);
                end
                if ($urandom_range(0, 1) == 1) begin
                    a = $urandom_range(0, N - 1);
                    b = $urandom_range(0, N - 1);
                    tlx[b] = tlx[a];
                    tly[b] = tly[a];
                end
            end
            if ($urandom_range(0, 49) == 0) ov = N'($urandom);
            if ($urandom_range(0, 1) == 1)
                hit_ch(1'($urandom_range(0, 24) == 0), $urandom_range(0, N - 1));
            else
                drive(1'($urandom_range(0, 499) != 0), 1'($urandom_range(0, 24) == 0),
                      W'($urandom), W'($urandom));
        end
        drive(1'b1, 1'b1, 11'd0, 11'd0);
        idle(2);

        @(posedge clk);
        #2;
        chk("summary_queue_drained", 32'(exp_sum.size()), 32'd0);
        chk("cycle_queue_drained", 32'(exp_cyc.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
